// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, fetch FSM states and the default reset PC
// for the instruction fetch front end.
package mips_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC select: jump_reg > jump > taken branch > sequential; purely combinational,
// zero latency, no backpressure (result is consumed only when the fetch FSM leaves EXEC).
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_lo,
    input  logic        branch,
    input  logic        branch_not,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic        taken;
    logic [31:0] br_off;

    always_comb begin
        taken    = (branch & alu_zero) | (branch_not & ~alu_zero);
        br_off   = {{14{instr_lo[15]}}, instr_lo[15:0], 2'b00};
        misalign = jump_reg & (jr_target[1:0] != 2'b00);

        if (jump_reg) begin
            next_pc = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr_lo, 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + br_off;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// PC owner and imem req/ack fetcher; ack in cycle N gives instr_valid in N+1, 2 cycles/instr minimum.
// imem_req is held until ack; stall holds EXEC (instr_valid stays high, pc/instr frozen).
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        branch_not,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        align_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         vld_q, vld_d;
    logic         req_q, req_d;
    logic         align_err_q, align_err_d;

    logic [31:0]  next_pc;
    logic         misalign;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_plus4   (pc_plus4),
        .instr_lo   (instr_q[25:0]),
        .branch     (branch),
        .branch_not (branch_not),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .alu_zero   (alu_zero),
        .jr_target  (jr_target),
        .next_pc    (next_pc),
        .misalign   (misalign)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        vld_d       = vld_q;
        req_d       = req_q;
        align_err_d = align_err_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                // rdata is only trusted on an ack while a request is outstanding
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    vld_d   = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_d        = next_pc;
                    vld_d       = 1'b0;
                    req_d       = 1'b1;
                    align_err_d = align_err_q | misalign;
                    state_d     = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            vld_q       <= 1'b0;
            req_q       <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            vld_q       <= vld_d;
            req_q       <= req_d;
            align_err_q <= align_err_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign pc          = pc_q;
    assign align_err   = align_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, randomized instructions against a
// reference next-PC model, and a reset-during-fetch sequence.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch, branch_not, jump, jump_reg, alu_zero;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        align_err;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .branch      (branch),
        .branch_not  (branch_not),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .alu_zero    (alu_zero),
        .jr_target   (jr_target),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int commits = 0;

    logic [31:0] m_pc;
    logic        m_align;

    always @(posedge clk) begin
        if (instr_valid && !stall) commits++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference next PC, computed from the architectural rules with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                             input logic jr, input logic j, input logic b,
                                             input logic bn, input logic z,
                                             input logic [31:0] tgt);
        logic [31:0] p4;
        int          off;
        p4 = cur + 32'd4;
        if (jr) return tgt - (tgt % 4);
        if (j)  return (p4 & 32'hF000_0000) + (w % 32'h0400_0000) * 4;
        if ((b && z) || (bn && !z)) begin
            off = int'($signed(w[15:0]));
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    task automatic run_instr(input logic [31:0] w, input logic jr, input logic j,
                             input logic b, input logic bn, input logic z,
                             input logic [31:0] tgt, input int ack_dly, input int stall_n,
                             input logic [31:0] exp_next, input logic exp_align);
        int t;
        int c0;
        logic [31:0] old_addr;
        t = 0;
        while (!imem_req && t < 20) begin
            tick();
            t++;
        end
        chk("req_seen", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("valid_low_in_fetch", instr_valid, 1'b0);
        old_addr = imem_addr;
        repeat (ack_dly) tick();
        if (ack_dly > 0) begin
            chk("addr_stable_wait", imem_addr, old_addr);
            chk("req_held_wait", imem_req, 1'b1);
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("valid_after_ack", instr_valid, 1'b1);
        chk("instr_latched", instr, w);
        chk("req_dropped", imem_req, 1'b0);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);

        jump_reg = jr; jump = j; branch = b; branch_not = bn; alu_zero = z; jr_target = tgt;
        c0 = commits;
        if (stall_n > 0) begin
            stall    = 1'b1;
            imem_ack = 1'b1;
            repeat (stall_n) tick();
            chk("stall_valid_held", instr_valid, 1'b1);
            chk("stall_pc_held", pc, m_pc);
            chk("stall_instr_held", instr, w);
            chk("stall_no_req", imem_req, 1'b0);
            imem_ack = 1'b0;
            stall    = 1'b0;
        end
        tick();
        chk("valid_one_commit", instr_valid, 1'b0);
        chk("next_req", imem_req, 1'b1);
        chk("next_addr", imem_addr, exp_next);
        chk("align_err", align_err, exp_align);
        chk("commit_count", commits - c0, 1);
        jump_reg = 0; jump = 0; branch = 0; branch_not = 0; alu_zero = 0;
        m_pc = exp_next;
    endtask

    typedef struct {
        logic [31:0] w;
        logic        jr, j, b, bn, z;
        logic [31:0] tgt;
        int          ack_dly;
        int          stall_n;
        logic [31:0] exp_next;
        logic        exp_align;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] w, tgt, nx;
        logic        jr, j, b, bn, z;

        vecs[0]  = '{32'h0000_0000, 0,0,0,0,0, 32'h0,         0,0, 32'h0000_0004, 0};
        vecs[1]  = '{32'h0800_0004, 0,1,0,0,0, 32'h0,         1,0, 32'h0000_0010, 0};
        vecs[2]  = '{32'h1000_FFFC, 0,0,1,0,1, 32'h0,         0,0, 32'h0000_0004, 0};
        vecs[3]  = '{32'h0800_0004, 0,1,0,0,0, 32'h0,         0,1, 32'h0000_0010, 0};
        vecs[4]  = '{32'h1000_FFFC, 0,0,1,0,0, 32'h0,         0,0, 32'h0000_0014, 0};
        vecs[5]  = '{32'h1400_0003, 0,0,0,1,0, 32'h0,         3,2, 32'h0000_0024, 0};
        vecs[6]  = '{32'h0000_0008, 1,0,0,0,0, 32'h3000_0000, 0,0, 32'h3000_0000, 0};
        vecs[7]  = '{32'h0800_0100, 0,1,0,0,0, 32'h0,         0,0, 32'h3000_0400, 0};
        vecs[8]  = '{32'h0000_0008, 1,0,0,0,0, 32'h3000_0000, 2,0, 32'h3000_0000, 0};
        vecs[9]  = '{32'h0C00_0100, 0,1,0,0,0, 32'h0,         0,0, 32'h3000_0400, 0};
        vecs[10] = '{32'h1000_0001, 0,0,1,1,1, 32'h0,         1,1, 32'h3000_0408, 0};
        vecs[11] = '{32'h0000_0008, 1,1,1,0,1, 32'h0000_0202, 0,0, 32'h0000_0200, 1};
        vecs[12] = '{32'h0000_0008, 1,0,0,0,0, 32'hFFFF_FFFC, 0,0, 32'hFFFF_FFFC, 1};
        vecs[13] = '{32'h0000_0000, 0,0,0,0,0, 32'h0,         0,0, 32'h0000_0000, 1};
        vecs[14] = '{32'h1000_FFFE, 0,0,1,0,1, 32'h0,         0,0, 32'hFFFF_FFFC, 1};
        vecs[15] = '{32'h1000_0002, 0,0,1,0,1, 32'h0,         0,0, 32'h0000_0008, 1};

        rst_n = 0; imem_ack = 0; imem_rdata = 0; stall = 0;
        branch = 0; branch_not = 0; jump = 0; jump_reg = 0; alu_zero = 0; jr_target = 0;
        m_pc = 32'h0; m_align = 0;

        repeat (3) tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_align", align_err, 1'b0);
        rst_n = 1;

        for (int i = 0; i < 16; i++) begin
            run_instr(vecs[i].w, vecs[i].jr, vecs[i].j, vecs[i].b, vecs[i].bn, vecs[i].z,
                      vecs[i].tgt, vecs[i].ack_dly, vecs[i].stall_n,
                      vecs[i].exp_next, vecs[i].exp_align);
        end

        m_align = 1'b1;
        for (int i = 0; i < 40; i++) begin
            w   = $urandom;
            jr  = ($urandom_range(0, 5) == 0);
            j   = ($urandom_range(0, 3) == 0);
            b   = $urandom_range(0, 1);
            bn  = $urandom_range(0, 1);
            z   = $urandom_range(0, 1);
            tgt = $urandom;
            if ($urandom_range(0, 1) == 1) tgt = tgt & 32'hFFFF_FFFC;
            nx  = ref_next(m_pc, w, jr, j, b, bn, z, tgt);
            if (jr && (tgt % 4 != 0)) m_align = 1'b1;
            run_instr(w, jr, j, b, bn, z, tgt, $urandom_range(0, 3), $urandom_range(0, 2),
                      nx, m_align);
        end

        // Reset in the middle of an outstanding fetch, with ack arriving during and after reset.
        chk("pre_reset_req", imem_req, 1'b1);
        rst_n = 0;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_instr", instr, 32'h0);
        chk("async_rst_valid", instr_valid, 1'b0);
        chk("async_rst_req", imem_req, 1'b0);
        chk("async_rst_align", align_err, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rst_ack_ignored_instr", instr, 32'h0);
        chk("rst_ack_ignored_valid", instr_valid, 1'b0);
        rst_n = 1;
        tick();
        chk("idle_ack_ignored_instr", instr, 32'h0);
        chk("idle_ack_ignored_valid", instr_valid, 1'b0);
        chk("refetch_req", imem_req, 1'b1);
        chk("refetch_addr", imem_addr, 32'h0);
        imem_ack = 1'b0;
        m_pc = 32'h0;
        run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0000_0004, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
